// File: rtl/servo_bank_if.sv
// Byte-wide register bus for servo_bank: strobed writes and registered reads.
interface servo_bank_if;
    logic [7:0] din;
    logic [7:0] address;
    logic       w_en;
    logic       r_en;
    logic [7:0] dout;

    modport master (output din, address, w_en, r_en, input dout);
    modport slave  (input din, address, w_en, r_en, output dout);
endinterface

// File: rtl/servo_bank.sv
// Bank of PWM servo channels with per-frame slew-limited positions, driven
// from a fixed 6.35 us tick and a FRAME_TICKS-long frame.
module servo_bank #(
    parameter int         NUM_CH       = 4,
    parameter logic [7:0] BASE_ADDRESS = 8'h00,
    parameter int         CLK_FREQ     = 16000000,
    parameter int         MIN_TICKS    = 91,
    parameter int         FRAME_TICKS  = 3150
) (
    input  logic              clk,
    input  logic              rst,
    servo_bank_if.slave       bus,
    output logic [NUM_CH-1:0] servo_pins
);
    // ceil(6.35e-6 * CLK_FREQ) done in exact integer arithmetic
    localparam longint TICK_CYCLES_L =
        (longint'(CLK_FREQ) * 64'sd635 + 64'sd99999999) / 64'sd100000000;
    localparam int TICK_CYCLES = int'(TICK_CYCLES_L);
    localparam int PRE_W       = (TICK_CYCLES > 1) ? $clog2(TICK_CYCLES) : 1;

    localparam logic [PRE_W-1:0] PRE_LAST   = PRE_W'(TICK_CYCLES - 1);
    localparam logic [11:0]      FRAME_LAST = 12'(FRAME_TICKS - 1);
    localparam logic [11:0]      MIN_W      = 12'(MIN_TICKS);
    localparam logic [7:0]       OFF_ENABLE = 8'(NUM_CH);
    localparam logic [7:0]       OFF_STEP   = 8'(NUM_CH + 1);
    localparam logic [7:0]       OFF_STATUS = 8'(NUM_CH + 2);

    logic [PRE_W-1:0]  prescaler;
    logic [11:0]       frame_cnt;
    logic              tick;
    logic              frame_end;

    logic [7:0]        target [NUM_CH];
    logic [7:0]        cur    [NUM_CH];
    logic [NUM_CH-1:0] enable;
    logic [NUM_CH-1:0] status;
    logic [7:0]        step;

    logic [8:0]        offset9;
    logic [7:0]        offset;
    logic              mapped;
    logic [7:0]        rdata;

    assign tick      = (prescaler == PRE_LAST);
    assign frame_end = tick && (frame_cnt == FRAME_LAST);

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            prescaler <= '0;
            frame_cnt <= '0;
        end else begin
            prescaler <= tick ? '0 : prescaler + 1'b1;
            if (tick)
                frame_cnt <= (frame_cnt == FRAME_LAST) ? 12'd0 : frame_cnt + 12'd1;
        end
    end

    // 9-bit subtraction so addresses below the window cannot wrap into it
    assign offset9 = {1'b0, bus.address} - {1'b0, BASE_ADDRESS};
    assign offset  = offset9[7:0];
    assign mapped  = !offset9[8] && (offset <= OFF_STATUS);

    always_comb begin
        status = '0;
        for (int i = 0; i < NUM_CH; i++)
            status[i] = (cur[i] != target[i]);
    end

    // NOTE: rdata gets a default before any branch so no latch is inferred.
    always_comb begin
        rdata = '0;
        for (int i = 0; i < NUM_CH; i++)
            if (offset == 8'(i))
                rdata = target[i];
        if (offset == OFF_ENABLE) rdata = 8'(enable);
        if (offset == OFF_STEP)   rdata = step;
        if (offset == OFF_STATUS) rdata = 8'(status);
    end

    // Move toward tgt by stp without overshoot; step 0 or disabled jumps straight there
    function automatic logic [7:0] next_cur(input logic [7:0] c, input logic [7:0] tgt,
                                            input logic [7:0] stp, input logic en);
        logic [8:0] up;
        logic [8:0] dn;
        up = {1'b0, c} + {1'b0, stp};
        dn = {1'b0, c} - {1'b0, stp};
        if (!en || stp == 8'd0)
            return tgt;
        if (c < tgt)
            return (up > {1'b0, tgt}) ? tgt : up[7:0];
        if (c > tgt)
            return (dn[8] || dn[7:0] < tgt) ? tgt : dn[7:0];
        return c;
    endfunction

    // NOTE: target/cur are small flop arrays, so they are reset like any other state.
    always_ff @(posedge clk) begin
        if (rst) begin
            enable   <= '0;
            step     <= '0;
            bus.dout <= '0;
            for (int i = 0; i < NUM_CH; i++) begin
                target[i] <= '0;
                cur[i]    <= '0;
            end
        end else begin
            if (frame_end)
                for (int i = 0; i < NUM_CH; i++)
                    cur[i] <= next_cur(cur[i], target[i], step, enable[i]);

            if (bus.w_en && mapped) begin
                for (int i = 0; i < NUM_CH; i++)
                    if (offset == 8'(i))
                        target[i] <= bus.din;
                if (offset == OFF_ENABLE) enable <= bus.din[NUM_CH-1:0];
                if (offset == OFF_STEP)   step   <= bus.din;
            end

            bus.dout <= (bus.r_en && mapped) ? rdata : 8'd0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            servo_pins <= '0;
        end else begin
            for (int i = 0; i < NUM_CH; i++)
                servo_pins[i] <= enable[i] && (frame_cnt < MIN_W + {4'b0000, cur[i]});
        end
    end
endmodule

// File: tb/tb_servo_bank.sv
// Directed bench for servo_bank on a scaled clock: 4-cycle tick, 300-tick frame.
module tb_servo_bank;
    localparam int         NUM_CH = 4;
    localparam logic [7:0] BASE   = 8'h10;
    // CLK_FREQ 500 kHz -> tick = ceil(3.175) = 4 cycles; frame = 300 * 4 = 1200 cycles
    localparam int         FRAME_CYC = 1200;

    localparam logic [7:0] A_T0    = BASE;
    localparam logic [7:0] A_T1    = BASE + 8'd1;
    localparam logic [7:0] A_EN    = BASE + 8'd4;
    localparam logic [7:0] A_STEP  = BASE + 8'd5;
    localparam logic [7:0] A_STAT  = BASE + 8'd6;
    localparam logic [7:0] A_UNMAP = BASE + 8'd7;
    localparam logic [7:0] A_BELOW = BASE - 8'd1;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic [NUM_CH-1:0] servo_pins;

    servo_bank_if bus ();

    servo_bank #(
        .NUM_CH      (NUM_CH),
        .BASE_ADDRESS(BASE),
        .CLK_FREQ    (500000),
        .MIN_TICKS   (5),
        .FRAME_TICKS (300)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .bus       (bus),
        .servo_pins(servo_pins)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string tag, input int got, input int exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: observed %0d (0x%0h), expected %0d (0x%0h)", tag, got, got, exp, exp);
        end
    endtask

    task automatic tick_clk();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [7:0] a, input logic [7:0] v);
        bus.address = a;
        bus.din     = v;
        bus.w_en    = 1'b1;
        tick_clk();
        bus.w_en    = 1'b0;
    endtask

    task automatic rd(input logic [7:0] a, output int d);
        bus.address = a;
        bus.r_en    = 1'b1;
        tick_clk();
        d           = int'(bus.dout);
        bus.r_en    = 1'b0;
    endtask

    task automatic rw(input logic [7:0] a, input logic [7:0] v, output int d);
        bus.address = a;
        bus.din     = v;
        bus.w_en    = 1'b1;
        bus.r_en    = 1'b1;
        tick_clk();
        d           = int'(bus.dout);
        bus.w_en    = 1'b0;
        bus.r_en    = 1'b0;
    endtask

    task automatic wait_pin(input int ch, input logic level);
        int n = 0;
        while (servo_pins[ch] !== level) begin
            tick_clk();
            n++;
            if (n > 3 * FRAME_CYC) begin
                check($sformatf("wait_pin%0d_timeout", ch), int'(servo_pins[ch]), int'(level));
                return;
            end
        end
    endtask

    // Starts on the first high sample of a pulse; ends on the first high sample of the next.
    // STATUS is read once during the low phase, so it reflects this frame's positions.
    task automatic pulse(input int ch, output int h, output int l, output int st);
        h  = 0;
        l  = 0;
        st = -1;
        while (servo_pins[ch] === 1'b1 && h < 3 * FRAME_CYC) begin
            h++;
            tick_clk();
        end
        while (servo_pins[ch] === 1'b0 && l < 3 * FRAME_CYC) begin
            if (l == 0) begin
                bus.address = A_STAT;
                bus.r_en    = 1'b1;
            end
            l++;
            tick_clk();
            if (l == 1) begin
                st       = int'(bus.dout);
                bus.r_en = 1'b0;
            end
        end
    endtask

    task automatic measure_next(input int ch, output int h, output int l, output int st);
        wait_pin(ch, 1'b0);
        wait_pin(ch, 1'b1);
        pulse(ch, h, l, st);
    endtask

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int d, h, l, st;
        int exp_h  [4] = '{420, 820, 1020, 1020};
        int exp_st [4] = '{1, 1, 0, 0};

        bus.din = '0; bus.address = '0; bus.w_en = 1'b0; bus.r_en = 1'b0;
        rst = 1'b1;
        repeat (3) tick_clk();
        check("reset_pins", int'(servo_pins), 0);
        check("reset_dout", int'(bus.dout), 0);
        rst = 1'b0;

        rd(A_T0, d);   check("reset_target0", d, 0);
        rd(A_EN, d);   check("reset_enable", d, 0);
        rd(A_STEP, d); check("reset_step", d, 0);
        rd(A_STAT, d); check("reset_status", d, 0);

        // Register map corners
        wr(A_EN, 8'hFF);
        rd(A_EN, d);    check("enable_masked", d, 'h0F);
        tick_clk();     check("dout_idle_zero", int'(bus.dout), 0);
        rd(A_UNMAP, d); check("unmapped_read", d, 0);
        rd(A_BELOW, d); check("below_base_read", d, 0);
        wr(A_STAT, 8'hFF);
        rd(A_STAT, d);  check("status_write_ignored", d, 0);
        rw(A_STEP, 8'h33, d); check("rw_returns_old", d, 0);
        rd(A_STEP, d);  check("rw_write_landed", d, 'h33);
        wr(A_STEP, 8'h00);

        // Position 0: (5 + 0) * 4 = 20 cycles high, 1200-cycle period
        measure_next(0, h, l, st);
        check("pos0_high", h, 20);
        check("pos0_period", h + l, FRAME_CYC);

        // Position 255: (5 + 255) * 4 = 1040 cycles high from the next frame
        wr(A_T0, 8'd255);
        rd(A_STAT, d);  check("status_pending", d, 1);
        measure_next(0, h, l, st);
        check("pos255_high", h, 1040);
        check("pos255_period", h + l, FRAME_CYC);
        check("pos255_status", st, 0);

        // Slew: back to 0, then STEP=100 toward 250
        wr(A_T0, 8'd0);
        measure_next(0, h, l, st);
        check("back_to_0_high", h, 20);
        wr(A_STEP, 8'd100);
        wr(A_T0, 8'd250);
        rd(A_STAT, d);  check("slew_status_start", d, 1);
        for (int k = 0; k < 4; k++) begin
            if (k == 0) measure_next(0, h, l, st);
            else        pulse(0, h, l, st);
            check($sformatf("slew_high_%0d", k), h, exp_h[k]);
            check($sformatf("slew_status_%0d", k), st, exp_st[k]);
        end

        // Write TARGET1 on the frame_end edge itself: first pulse pending after.
        // Now at the first high sample after frame_end E0; next frame_end is 1199 edges on.
        repeat (FRAME_CYC - 2) @(posedge clk);
        #1;
        wr(A_T1, 8'd40);
        measure_next(1, h, l, st);
        check("t1_same_frame_high", h, 20);
        check("t1_same_frame_status", st, 'h02);
        pulse(1, h, l, st);
        check("t1_next_frame_high", h, 180);
        check("t1_next_frame_status", st, 0);

        // Clear ENABLE bit2 mid-pulse, then set it again
        wr(A_EN, 8'h0B);
        check("en_clear_same_cycle", int'(servo_pins), 'hF);
        tick_clk();
        check("en_clear_next_cycle", int'(servo_pins), 'hB);
        wr(A_EN, 8'h0F);
        check("en_set_same_cycle", int'(servo_pins), 'hB);
        tick_clk();
        check("en_set_resumes", int'(servo_pins), 'hF);

        // Reset mid-pulse while a read is being requested
        bus.address = A_EN;
        bus.r_en    = 1'b1;
        rst         = 1'b1;
        tick_clk();
        check("midreset_pins", int'(servo_pins), 0);
        check("midreset_dout", int'(bus.dout), 0);
        bus.r_en = 1'b0;
        rst      = 1'b0;

        // Frame restarts at 0: pin high from 2 cycles after reset until count 5 -> 19 cycles
        wr(A_EN, 8'h01);
        tick_clk();
        check("restart_first_high", int'(servo_pins[0]), 1);
        pulse(0, h, l, st);
        check("restart_high", h, 19);
        check("restart_low", l, FRAME_CYC - 20);
        pulse(0, h, l, st);
        check("restart_next_high", h, 20);

        for (int i = 0; i < NUM_CH; i++) begin
            rd(BASE + 8'(i), d);
            check($sformatf("postreset_target%0d", i), d, 0);
        end
        rd(A_STEP, d); check("postreset_step", d, 0);
        rd(A_STAT, d); check("postreset_status", d, 0);
        rd(A_EN, d);   check("postreset_enable", d, 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
